// File: rtl/stq_svc_ctrl_pkg.sv
// Shared types and helpers for the store-queue service controller.
package stq_svc_ctrl_pkg;

    localparam int IDX_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_DRAIN,
        ST_ADVANCE,
        ST_DONE
    } svc_state_t;

    // Increment an index of 'width' bits, sticking at all-ones instead of wrapping.
    function automatic logic [IDX_MAX_W-1:0] idx_sat_inc(
        input logic [IDX_MAX_W-1:0] idx,
        input int unsigned          width
    );
        logic [IDX_MAX_W-1:0] max_val;
        if (width >= IDX_MAX_W)
            max_val = '1;
        else
            max_val = (IDX_MAX_W'(1) << width) - IDX_MAX_W'(1);
        return (idx == max_val) ? idx : idx + IDX_MAX_W'(1);
    endfunction

endpackage

// File: rtl/stq_svc_adder_tree.sv
// Purpose: modulo-2^DATA_PRECISION sum of NUM_UNITs head values (carries dropped).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its operands.
module stq_svc_adder_tree #(
    parameter int NUM_UNITs      = 4,
    parameter int DATA_PRECISION = 32
) (
    input  logic [NUM_UNITs*DATA_PRECISION-1:0] operands,
    output logic [DATA_PRECISION-1:0]           sum
);

    always_comb begin
        sum = '0;
        for (int u = 0; u < NUM_UNITs; u++)
            sum = sum + operands[u*DATA_PRECISION +: DATA_PRECISION];
    end

endmodule

// File: rtl/stq_svc_ctrl.sv
// Purpose: walks block indices, waits for all units, drains them in lock-step into one merged beat.
// Latency: pop and merged beat register on the same edge, beat visible 1 cycle after rd_en.
// Backpressure: out_valid && !out_ready holds the beat and suppresses pops, no bubble, no loss.
module stq_svc_ctrl
    import stq_svc_ctrl_pkg::*;
#(
    parameter int NUM_UNITs      = 4,
    parameter int UNIT_INIT_BIT  = 8,
    parameter int DATA_PRECISION = 32,
    parameter int BITS_BEAT_CNT  = 16
) (
    input  logic                                clk,
    input  logic                                rst_b,
    input  logic                                global_en,
    input  logic                                start,
    input  logic [UNIT_INIT_BIT-1:0]            last_idx,
    input  logic                                flush,
    input  logic [NUM_UNITs-1:0]                svc_ready,
    input  logic [NUM_UNITs-1:0]                deliver_vld,
    input  logic [NUM_UNITs*DATA_PRECISION-1:0] do_stq_buff,
    output logic [UNIT_INIT_BIT-1:0]            svc_idx,
    output logic [UNIT_INIT_BIT-1:0]            svc_threshold_idx,
    output logic [NUM_UNITs-1:0]                rd_en,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [UNIT_INIT_BIT-1:0]            out_idx,
    output logic [DATA_PRECISION-1:0]           out_value,
    output logic [BITS_BEAT_CNT-1:0]            beat_cnt,
    output logic                                busy,
    output logic                                done
);

    svc_state_t                 state, state_nxt;
    logic [UNIT_INIT_BIT-1:0]   last_idx_q;
    logic                       load_pass, adv_idx, fire;
    logic [DATA_PRECISION-1:0]  beat_sum;

    stq_svc_adder_tree #(
        .NUM_UNITs      (NUM_UNITs),
        .DATA_PRECISION (DATA_PRECISION)
    ) u_adder_tree (
        .operands (do_stq_buff),
        .sum      (beat_sum)
    );

    assign svc_threshold_idx = UNIT_INIT_BIT'(idx_sat_inc(IDX_MAX_W'(svc_idx), UNIT_INIT_BIT));
    assign fire  = global_en && (state == ST_DRAIN) && (|deliver_vld) && (!out_valid || out_ready);
    assign rd_en = fire ? deliver_vld : '0;
    assign busy  = (state != ST_IDLE) && (state != ST_DONE);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_pass = 1'b0;
        adv_idx   = 1'b0;
        if (global_en) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_WAIT_RDY;
                        load_pass = 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if ((&svc_ready) || flush)
                        state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (deliver_vld == '0)
                        state_nxt = ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (svc_idx == last_idx_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_RDY;
                        adv_idx   = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            svc_idx    <= '0;
            last_idx_q <= '0;
            beat_cnt   <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_value  <= '0;
        end else begin
            if (load_pass) begin
                svc_idx    <= '0;
                last_idx_q <= last_idx;
            end else if (adv_idx) begin
                // ADVANCE only steps when below last_idx_q, so the saturating value is a plain +1 here.
                svc_idx <= svc_threshold_idx;
            end

            if (load_pass || adv_idx)
                beat_cnt <= '0;
            else if (fire && (beat_cnt != '1))
                beat_cnt <= beat_cnt + BITS_BEAT_CNT'(1);

            // The handshake is independent of global_en so a stalled pipe can still hand off its last beat.
            if (fire) begin
                out_valid <= 1'b1;
                out_idx   <= svc_idx;
                out_value <= beat_sum;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
